// File: rtl/qspi_read_arbiter_pkg.sv
// Shared types for the two-client QSPI read arbiter: FSM states, client index
// and the default burst length before a waiting peer may take the flash.
package qspi_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_STREAM,
      ST_STOP
   } arb_state_t;

   typedef logic client_idx_t;

   localparam int DEF_MAX_BURST = 16;

   function automatic client_idx_t peer_of(input client_idx_t c);
      return ~c;
   endfunction

endpackage

// File: rtl/qspi_read_arbiter_if.sv
// Flash-controller side of the arbiter: read strobes and start address out,
// returned word and busy flag back in.
interface qspi_read_arbiter_if #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 16
);

   logic                 fl_start_read;
   logic                 fl_continue_read;
   logic                 fl_stop_read;
   logic [ADDR_BITS-1:0] fl_addr;
   logic [DATA_BITS-1:0] fl_data;
   logic                 fl_busy;

   modport master (
      output fl_start_read, fl_continue_read, fl_stop_read, fl_addr,
      input  fl_data, fl_busy
   );

   modport slave (
      input  fl_start_read, fl_continue_read, fl_stop_read, fl_addr,
      output fl_data, fl_busy
   );

endinterface

// File: rtl/qspi_read_arbiter_client_ctx.sv
// Per-client resume context: remembers where a preempted stream stopped so the
// client's next start continues from there instead of its request address.
module qspi_arb_client_ctx
   import qspi_arb_pkg::*;
#(
   parameter int ADDR_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 suspend,
   input  logic                 clear,
   input  logic [ADDR_BITS-1:0] cur_addr,
   output logic                 suspended,
   output logic [ADDR_BITS-1:0] saved_addr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         suspended  <= 1'b0;
         saved_addr <= '0;
      end else if (suspend) begin
         suspended  <= 1'b1;
         saved_addr <= cur_addr;
      end else if (clear) begin
         suspended  <= 1'b0;
      end
   end

endmodule

// File: rtl/qspi_read_arbiter.sv
// Two-client QSPI read-stream arbiter with round-robin and burst preemption.
// Define ARB_PRIORITY0_EN to make client 0 win ties and never be preempted.
module qspi_read_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 16,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 c0_req,
   input  logic [ADDR_BITS-1:0] c0_addr,
   input  logic                 c0_next,
   input  logic                 c0_done,
   output logic                 c0_grant,
   output logic                 c0_valid,
   output logic [DATA_BITS-1:0] c0_data,
   input  logic                 c1_req,
   input  logic [ADDR_BITS-1:0] c1_addr,
   input  logic                 c1_next,
   input  logic                 c1_done,
   output logic                 c1_grant,
   output logic                 c1_valid,
   output logic [DATA_BITS-1:0] c1_data,
   qspi_read_arbiter_if.master  fl
);

   localparam int                   CNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
   localparam logic [ADDR_BITS-1:0] ALIGN_MASK = {{(ADDR_BITS-1){1'b1}}, 1'b0};
   localparam logic [ADDR_BITS-1:0] WORD_STEP  = ADDR_BITS'(2);

   arb_state_t           state, state_nxt;
   client_idx_t          owner, last_grant, win;
   logic [1:0]           req_v, next_v, done_v, susp_v;
   logic [CNT_W-1:0]     word_cnt;
   logic [ADDR_BITS-1:0] cur_addr, start_addr, saved0, saved1;
   logic                 start_s, cont_s, stop_s, release_s, preempt_s;
   logic                 preempt_ok, active;

   assign req_v  = {c1_req, c0_req};
   assign next_v = {c1_next, c0_next};
   assign done_v = {c1_done, c0_done};

`ifdef ARB_PRIORITY0_EN
   assign preempt_ok = (owner == 1'b1);
   always_comb win = req_v[0] ? 1'b0 : 1'b1;
`else
   assign preempt_ok = 1'b1;
   always_comb begin
      if (&req_v) win = peer_of(last_grant);
      else        win = req_v[0] ? 1'b0 : 1'b1;
   end
`endif

   // A suspended client resumes from where it was cut off.
   always_comb begin
      if (win) start_addr = susp_v[1] ? saved1 : (c1_addr & ALIGN_MASK);
      else     start_addr = susp_v[0] ? saved0 : (c0_addr & ALIGN_MASK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start_s) state_nxt = ST_START;
         ST_START:  state_nxt = ST_WAIT;
         ST_WAIT:   if (!fl.fl_busy) state_nxt = ST_STREAM;
         ST_STREAM: begin
            if (stop_s)      state_nxt = ST_STOP;
            else if (cont_s) state_nxt = ST_WAIT;
         end
         ST_STOP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Release beats preemption, which beats a continue in the same cycle.
   always_comb begin
      start_s   = 1'b0;
      cont_s    = 1'b0;
      stop_s    = 1'b0;
      release_s = 1'b0;
      preempt_s = 1'b0;
      unique case (state)
         ST_IDLE: start_s = (|req_v) && !rst;
         ST_STREAM: begin
            if (done_v[owner] || !req_v[owner]) begin
               stop_s    = 1'b1;
               release_s = 1'b1;
            end else if (word_cnt == CNT_MAX && req_v[peer_of(owner)] && preempt_ok) begin
               stop_s    = 1'b1;
               preempt_s = 1'b1;
            end else if (next_v[owner]) begin
               cont_s = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign active              = (state == ST_START) || (state == ST_WAIT) || (state == ST_STREAM);
   assign c0_grant            = active && (owner == 1'b0);
   assign c1_grant            = active && (owner == 1'b1);
   assign fl.fl_start_read    = start_s;
   assign fl.fl_continue_read = cont_s;
   assign fl.fl_stop_read     = stop_s;
   assign fl.fl_addr          = start_s ? start_addr : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         word_cnt   <= '0;
         cur_addr   <= '0;
         c0_valid   <= 1'b0;
         c1_valid   <= 1'b0;
         c0_data    <= '0;
         c1_data    <= '0;
      end else begin
         c0_valid <= 1'b0;
         c1_valid <= 1'b0;
         if (start_s) begin
            owner      <= win;
            last_grant <= win;
            word_cnt   <= '0;
            cur_addr   <= start_addr;
         end
         if (state == ST_WAIT && !fl.fl_busy) begin
            if (owner) begin
               c1_valid <= 1'b1;
               c1_data  <= fl.fl_data;
            end else begin
               c0_valid <= 1'b1;
               c0_data  <= fl.fl_data;
            end
         end
         if (cont_s) begin
            cur_addr <= cur_addr + WORD_STEP;
            if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_ONE;
         end
      end
   end

   qspi_arb_client_ctx #(.ADDR_BITS(ADDR_BITS)) u_ctx0 (
      .clk        (clk),
      .rst        (rst),
      .suspend    (preempt_s && owner == 1'b0),
      .clear      ((release_s && owner == 1'b0) || (start_s && win == 1'b0)),
      .cur_addr   (cur_addr),
      .suspended  (susp_v[0]),
      .saved_addr (saved0)
   );

   qspi_arb_client_ctx #(.ADDR_BITS(ADDR_BITS)) u_ctx1 (
      .clk        (clk),
      .rst        (rst),
      .suspend    (preempt_s && owner == 1'b1),
      .clear      ((release_s && owner == 1'b1) || (start_s && win == 1'b1)),
      .cur_addr   (cur_addr),
      .suspended  (susp_v[1]),
      .saved_addr (saved1)
   );

endmodule

// File: tb/tb_qspi_read_arbiter.sv
// Directed bench for qspi_read_arbiter with a small latency-2 flash model whose
// word at address A is A[15:0] ^ 16'hC3C3.
module tb_qspi_read_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_req, c0_next, c0_done, c0_grant, c0_valid;
   logic        c1_req, c1_next, c1_done, c1_grant, c1_valid;
   logic [23:0] c0_addr, c1_addr;
   logic [15:0] c0_data, c1_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n_start  = 0;
   int n_cont   = 0;
   int n_stop   = 0;

   logic [23:0] fm_addr;
   int          fm_cnt;

   qspi_read_arbiter_if #(.ADDR_BITS(24), .DATA_BITS(16)) fl_if ();

   qspi_read_arbiter #(.ADDR_BITS(24), .DATA_BITS(16), .MAX_BURST(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .c0_req   (c0_req),
      .c0_addr  (c0_addr),
      .c0_next  (c0_next),
      .c0_done  (c0_done),
      .c0_grant (c0_grant),
      .c0_valid (c0_valid),
      .c0_data  (c0_data),
      .c1_req   (c1_req),
      .c1_addr  (c1_addr),
      .c1_next  (c1_next),
      .c1_done  (c1_done),
      .c1_grant (c1_grant),
      .c1_valid (c1_valid),
      .c1_data  (c1_data),
      .fl       (fl_if)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] flash_word(input logic [23:0] a);
      return a[15:0] ^ 16'hC3C3;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         fl_if.fl_busy <= 1'b0;
         fl_if.fl_data <= '0;
         fm_cnt        <= 0;
         fm_addr       <= '0;
      end else if (fl_if.fl_start_read) begin
         fm_addr       <= fl_if.fl_addr;
         fm_cnt        <= 2;
         fl_if.fl_busy <= 1'b1;
      end else if (fl_if.fl_continue_read) begin
         fm_addr       <= fm_addr + 24'd2;
         fm_cnt        <= 2;
         fl_if.fl_busy <= 1'b1;
      end else if (fl_if.fl_busy) begin
         if (fm_cnt == 1) begin
            fl_if.fl_busy <= 1'b0;
            fl_if.fl_data <= flash_word(fm_addr);
         end else begin
            fm_cnt <= fm_cnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (fl_if.fl_start_read)    n_start <= n_start + 1;
      if (fl_if.fl_continue_read) n_cont  <= n_cont + 1;
      if (fl_if.fl_stop_read)     n_stop  <= n_stop + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input bit c, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ((c ? c1_valid : c0_valid) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      c0_req = 1'b1; c0_addr = 24'h000010; c0_next = 1'b0; c0_done = 1'b0;
      c1_req = 1'b0; c1_addr = 24'h000000; c1_next = 1'b0; c1_done = 1'b0;
      cyc();
      cyc();
      n_checks++; if (fl_if.fl_start_read !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", fl_if.fl_start_read); end
      n_checks++; if ({c0_grant, c1_grant} !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", {c0_grant, c1_grant}); end
      n_checks++; if ({c0_valid, c1_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b want 00", {c0_valid, c1_valid}); end
      n_checks++; if ({c0_data, c1_data} !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {c0_data, c1_data}); end
      n_checks++; if ({fl_if.fl_continue_read, fl_if.fl_stop_read} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b want 00", {fl_if.fl_continue_read, fl_if.fl_stop_read}); end
      c0_req = 1'b0;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      bit ok;
      c0_addr = 24'h000100;
      c0_req  = 1'b1;
      #1;
      n_checks++; if (fl_if.fl_start_read !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", fl_if.fl_start_read); end
      n_checks++; if (fl_if.fl_addr !== 24'h000100) begin n_fail++; $display("FAIL single_addr: got %h want 000100", fl_if.fl_addr); end
      cyc();
      n_checks++; if ({c1_grant, c0_grant} !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", {c1_grant, c0_grant}); end
      c0_next = 1'b1;
      #1;
      n_checks++; if (fl_if.fl_continue_read !== 1'b0) begin n_fail++; $display("FAIL next_outside_stream: got %b want 0", fl_if.fl_continue_read); end
      c0_next = 1'b0;
      wait_valid(1'b0, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_valid_timeout: got %b want 1", ok); end
      n_checks++; if (c0_data !== 16'hC2C3) begin n_fail++; $display("FAIL single_word0: got %h want C2C3", c0_data); end
      c1_next = 1'b1;
      #1;
      n_checks++; if (fl_if.fl_continue_read !== 1'b0) begin n_fail++; $display("FAIL next_from_peer: got %b want 0", fl_if.fl_continue_read); end
      c1_next = 1'b0;
      c0_next = 1'b1;
      #1;
      n_checks++; if (fl_if.fl_continue_read !== 1'b1) begin n_fail++; $display("FAIL single_continue: got %b want 1", fl_if.fl_continue_read); end
      cyc();
      c0_next = 1'b0;
      wait_valid(1'b0, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_valid2_timeout: got %b want 1", ok); end
      n_checks++; if (c0_data !== 16'hC2C1) begin n_fail++; $display("FAIL single_word1: got %h want C2C1", c0_data); end
      cyc();
      n_checks++; if ({c0_valid, c0_data} !== {1'b0, 16'hC2C1}) begin n_fail++; $display("FAIL data_hold: got %b/%h want 0/C2C1", c0_valid, c0_data); end
      c0_done = 1'b1;
      #1;
      n_checks++; if (fl_if.fl_stop_read !== 1'b1) begin n_fail++; $display("FAIL single_stop: got %b want 1", fl_if.fl_stop_read); end
      cyc();
      c0_done = 1'b0;
      c0_req  = 1'b0;
      n_checks++; if (c0_grant !== 1'b0) begin n_fail++; $display("FAIL single_grant_drop: got %b want 0", c0_grant); end
      cyc();
   endtask

   task automatic test_done_next();
      bit ok;
      int c0n;
      c0_addr = 24'h000140;
      c0_req  = 1'b1;
      cyc();
      wait_valid(1'b0, ok);
      n_checks++; if ({ok, c0_data} !== {1'b1, 16'hC283}) begin n_fail++; $display("FAIL dn_word: got %b/%h want 1/C283", ok, c0_data); end
      c0n     = n_cont;
      c0_next = 1'b1;
      c0_done = 1'b1;
      #1;
      n_checks++; if ({fl_if.fl_stop_read, fl_if.fl_continue_read} !== 2'b10) begin n_fail++; $display("FAIL dn_strobes: got %b want 10", {fl_if.fl_stop_read, fl_if.fl_continue_read}); end
      cyc();
      c0_next = 1'b0;
      #1;
      n_checks++; if (n_cont !== c0n) begin n_fail++; $display("FAIL dn_no_continue: got %0d want %0d", n_cont, c0n); end
      n_checks++; if (fl_if.fl_start_read !== 1'b0) begin n_fail++; $display("FAIL start_in_stop: got %b want 0", fl_if.fl_start_read); end
      c0_req  = 1'b0;
      c0_done = 1'b0;
      cyc();
   endtask

   task automatic test_arb();
      bit ok;
      do_reset();
      c0_addr = 24'h000200;
      c1_addr = 24'h000401;
      c0_req  = 1'b1;
      c1_req  = 1'b1;
      #1;
      n_checks++; if ({fl_if.fl_start_read, fl_if.fl_addr} !== {1'b1, 24'h000200}) begin n_fail++; $display("FAIL arb_first: got %b/%h want 1/000200", fl_if.fl_start_read, fl_if.fl_addr); end
      cyc();
      n_checks++; if ({c1_grant, c0_grant} !== 2'b01) begin n_fail++; $display("FAIL arb_grant0: got %b want 01", {c1_grant, c0_grant}); end
      wait_valid(1'b0, ok);
      n_checks++; if ({ok, c0_data} !== {1'b1, 16'hC1C3}) begin n_fail++; $display("FAIL arb_word0: got %b/%h want 1/C1C3", ok, c0_data); end
      c0_done = 1'b1;
      cyc();
      c0_done = 1'b0;
      c0_req  = 1'b0;
      cyc();
      n_checks++; if ({fl_if.fl_start_read, fl_if.fl_addr} !== {1'b1, 24'h000400}) begin n_fail++; $display("FAIL arb_second: got %b/%h want 1/000400", fl_if.fl_start_read, fl_if.fl_addr); end
      cyc();
      n_checks++; if ({c1_grant, c0_grant} !== 2'b10) begin n_fail++; $display("FAIL arb_grant1: got %b want 10", {c1_grant, c0_grant}); end
      wait_valid(1'b1, ok);
      n_checks++; if ({ok, c1_data} !== {1'b1, 16'hC7C3}) begin n_fail++; $display("FAIL arb_word1: got %b/%h want 1/C7C3", ok, c1_data); end
      c1_done = 1'b1;
      cyc();
      c1_done = 1'b0;
      c1_req  = 1'b0;
      cyc();
   endtask

`ifdef ARB_PRIORITY0_EN
   task automatic test_priority();
      bit ok, all_ok;
      int s0;
      do_reset();
      c0_addr = 24'h000000;
      c0_req  = 1'b1;
      cyc();
      c1_addr = 24'h000800;
      c1_req  = 1'b1;
      s0      = n_stop;
      all_ok  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wait_valid(1'b0, ok);
         if (!ok) all_ok = 1'b0;
         c0_next = 1'b1;
         cyc();
         c0_next = 1'b0;
      end
      wait_valid(1'b0, ok);
      n_checks++; if ({all_ok, ok} !== 2'b11) begin n_fail++; $display("FAIL prio_valid_timeout: got %b want 11", {all_ok, ok}); end
      n_checks++; if (c0_data !== 16'hC393) begin n_fail++; $display("FAIL prio_word40: got %h want C393", c0_data); end
      n_checks++; if ({c0_grant, fl_if.fl_stop_read} !== 2'b10) begin n_fail++; $display("FAIL prio_no_preempt: got %b want 10", {c0_grant, fl_if.fl_stop_read}); end
      n_checks++; if (n_stop !== s0) begin n_fail++; $display("FAIL prio_stop_count: got %0d want %0d", n_stop, s0); end
      c0_done = 1'b1;
      cyc();
      c0_done = 1'b0;
      c0_req  = 1'b0;
      c1_req  = 1'b0;
      cyc();
   endtask
`else
   task automatic test_preempt();
      bit ok, all_ok;
      do_reset();
      c0_addr = 24'h000000;
      c0_req  = 1'b1;
      cyc();
      c1_addr = 24'h000800;
      c1_req  = 1'b1;
      all_ok  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wait_valid(1'b0, ok);
         if (!ok) all_ok = 1'b0;
         c0_next = 1'b1;
         cyc();
         c0_next = 1'b0;
      end
      c0_addr = 24'h000300;
      wait_valid(1'b0, ok);
      n_checks++; if ({all_ok, ok} !== 2'b11) begin n_fail++; $display("FAIL pre_valid_timeout: got %b want 11", {all_ok, ok}); end
      n_checks++; if (c0_data !== 16'hC3E3) begin n_fail++; $display("FAIL pre_word16: got %h want C3E3", c0_data); end
      n_checks++; if ({c0_grant, fl_if.fl_stop_read} !== 2'b11) begin n_fail++; $display("FAIL pre_stop: got %b want 11", {c0_grant, fl_if.fl_stop_read}); end
      cyc();
      n_checks++; if (c0_grant !== 1'b0) begin n_fail++; $display("FAIL pre_grant_drop: got %b want 0", c0_grant); end
      cyc();
      n_checks++; if ({fl_if.fl_start_read, fl_if.fl_addr} !== {1'b1, 24'h000800}) begin n_fail++; $display("FAIL pre_peer_start: got %b/%h want 1/000800", fl_if.fl_start_read, fl_if.fl_addr); end
      cyc();
      n_checks++; if ({c1_grant, c0_grant} !== 2'b10) begin n_fail++; $display("FAIL pre_peer_grant: got %b want 10", {c1_grant, c0_grant}); end
      wait_valid(1'b1, ok);
      n_checks++; if ({ok, c1_data} !== {1'b1, 16'hCBC3}) begin n_fail++; $display("FAIL pre_peer_word: got %b/%h want 1/CBC3", ok, c1_data); end
      c1_done = 1'b1;
      cyc();
      c1_done = 1'b0;
      c1_req  = 1'b0;
      cyc();
      n_checks++; if ({fl_if.fl_start_read, fl_if.fl_addr} !== {1'b1, 24'h000020}) begin n_fail++; $display("FAIL pre_resume_addr: got %b/%h want 1/000020", fl_if.fl_start_read, fl_if.fl_addr); end
      cyc();
      wait_valid(1'b0, ok);
      n_checks++; if ({ok, c0_data} !== {1'b1, 16'hC3E3}) begin n_fail++; $display("FAIL pre_resume_word: got %b/%h want 1/C3E3", ok, c0_data); end
      c0_done = 1'b1;
      cyc();
      c0_done = 1'b0;
      c0_req  = 1'b0;
      cyc();
   endtask
`endif

   task automatic test_reset_mid();
      bit ok;
      int s0;
      c0_addr = 24'h000600;
      c0_req  = 1'b1;
      cyc();
      cyc();
      n_checks++; if ({c0_grant, fl_if.fl_busy} !== 2'b11) begin n_fail++; $display("FAIL mid_in_wait: got %b want 11", {c0_grant, fl_if.fl_busy}); end
      s0  = n_stop;
      rst = 1'b1;
      #1;
      n_checks++; if ({c0_grant, c1_grant, c0_valid, c1_valid} !== 4'b0000) begin n_fail++; $display("FAIL mid_ctrl: got %b want 0000", {c0_grant, c1_grant, c0_valid, c1_valid}); end
      n_checks++; if (c0_data !== 16'h0000) begin n_fail++; $display("FAIL mid_data: got %h want 0000", c0_data); end
      n_checks++; if ({fl_if.fl_start_read, fl_if.fl_continue_read, fl_if.fl_stop_read} !== 3'b000) begin n_fail++; $display("FAIL mid_strobes: got %b want 000", {fl_if.fl_start_read, fl_if.fl_continue_read, fl_if.fl_stop_read}); end
      cyc();
      n_checks++; if (n_stop !== s0) begin n_fail++; $display("FAIL mid_no_stop: got %0d want %0d", n_stop, s0); end
      c0_addr = 24'h000700;
      rst     = 1'b0;
      #1;
      n_checks++; if ({fl_if.fl_start_read, fl_if.fl_addr} !== {1'b1, 24'h000700}) begin n_fail++; $display("FAIL mid_restart: got %b/%h want 1/000700", fl_if.fl_start_read, fl_if.fl_addr); end
      cyc();
      wait_valid(1'b0, ok);
      n_checks++; if ({ok, c0_data} !== {1'b1, 16'hC4C3}) begin n_fail++; $display("FAIL mid_word: got %b/%h want 1/C4C3", ok, c0_data); end
      c0_done = 1'b1;
      cyc();
      c0_done = 1'b0;
      c0_req  = 1'b0;
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_done_next();
      test_arb();
`ifdef ARB_PRIORITY0_EN
      test_priority();
`else
      test_preempt();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
